pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 199 +++++++++++++++++++
 tb/tb_pixel_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// ---------------------------------------------------------------------------
// pixel_streamer
//
// Holds one image frame in an internal buffer and, on request, streams it
// pixel by pixel to a classifier, then waits (bounded) for the classifier's
// digit result.
//
// Parameters
//   IMG_PIXELS : pixels per frame (default 784 = 28x28)
//   PIX_GAP    : idle cycles inserted after every streamed pixel
//   TIMEOUT    : cycles to wait for a classifier result after the last pixel
//
// Ports
//   clk         : single clock, rising edge
//   rst         : asynchronous active-high reset
//   wr_en       : frame-buffer write strobe (honoured only while not busy)
//   wr_addr     : frame-buffer write address (dropped if >= IMG_PIXELS)
//   wr_data     : frame-buffer write data
//   start       : request to stream the stored frame (honoured only in IDLE)
//   busy        : high while streaming or awaiting the result
//   pixel_out   : pixel to the classifier, 0 when pixel_valid is low
//   pixel_valid : qualifies pixel_out
//   digit_in    : classifier result
//   digit_valid : qualifies digit_in (only looked at while waiting)
//   result      : last captured classification
//   done        : one-cycle pulse when result is captured
//   timeout_err : one-cycle pulse when the wait expires without a result
// ---------------------------------------------------------------------------
module pixel_streamer #(
    parameter int IMG_PIXELS = 784,
    parameter int PIX_GAP    = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic [7:0] pixel_out,
    output logic       pixel_valid,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic [3:0] result,
    output logic       done,
    output logic       timeout_err
);

    // Counter widths sized so the largest value each one holds never wraps.
    localparam int IW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int GW = (PIX_GAP > 0) ? $clog2(PIX_GAP + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(IMG_PIXELS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(PIX_GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [10:0]   ADDR_LIM = 11'(IMG_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic [IW-1:0]   idx_q;     // index of the pixel slot currently on the output
    logic [GW-1:0]   ph_q;      // 0 = pixel cycle, 1..PIX_GAP = gap cycles after it
    logic [TW-1:0]   tmo_q;     // WAIT cycles already elapsed
    logic            pv_q;
    logic [7:0]      po_q;
    logic [3:0]      result_q;
    logic            done_q;
    logic            terr_q;

    logic [7:0]      mem_q [IMG_PIXELS];

    logic [IW-1:0]   idx_inc_d;
    logic [IW-1:0]   rd_idx_d;
    logic [7:0]      rd_data_d;
    logic            wr_ok_d;

    // Buffer write qualification: only while idle and only for in-range addresses.
    always_comb begin
        wr_ok_d = 1'b0;
        if (wr_en && !busy_q && ({1'b0, wr_addr} < ADDR_LIM)) begin
            wr_ok_d = 1'b1;
        end else begin
            wr_ok_d = 1'b0;
        end
    end

    // Read address: the pixel that will be on the output after the coming edge.
    // From IDLE that is pixel 0; on the final slot the address is parked at 0
    // so it never points past the end of the buffer.
    always_comb begin
        idx_inc_d = idx_q + IW'(1);
        rd_idx_d  = {IW{1'b0}};
        if ((state_q == ST_STREAM) && (idx_q != LAST_IDX)) begin
            rd_idx_d = idx_inc_d;
        end else begin
            rd_idx_d = {IW{1'b0}};
        end
        rd_data_d = mem_q[rd_idx_d];
    end

    // Frame buffer storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_d) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            idx_q    <= {IW{1'b0}};
            ph_q     <= {GW{1'b0}};
            tmo_q    <= {TW{1'b0}};
            pv_q     <= 1'b0;
            po_q     <= 8'h00;
            result_q <= 4'h0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            terr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // First pixel appears in the very next cycle.
                        state_q <= ST_STREAM;
                        busy_q  <= 1'b1;
                        idx_q   <= {IW{1'b0}};
                        ph_q    <= {GW{1'b0}};
                        pv_q    <= 1'b1;
                        po_q    <= rd_data_d;
                    end else begin
                        pv_q <= 1'b0;
                        po_q <= 8'h00;
                    end
                end
                ST_STREAM: begin
                    if (ph_q != GAP_LAST) begin
                        // Still inside this pixel's slot: emit a gap cycle.
                        ph_q <= ph_q + GW'(1);
                        pv_q <= 1'b0;
                        po_q <= 8'h00;
                    end else if (idx_q == LAST_IDX) begin
                        // Last slot (including its gap) finished.
                        state_q <= ST_WAIT;
                        tmo_q   <= {TW{1'b0}};
                        pv_q    <= 1'b0;
                        po_q    <= 8'h00;
                    end else begin
                        idx_q <= idx_inc_d;
                        ph_q  <= {GW{1'b0}};
                        pv_q  <= 1'b1;
                        po_q  <= rd_data_d;
                    end
                end
                ST_WAIT: begin
                    pv_q <= 1'b0;
                    po_q <= 8'h00;
                    // A result arriving on the expiry cycle still counts as a result.
                    if (digit_valid) begin
                        result_q <= digit_in;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        terr_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    pv_q    <= 1'b0;
                    po_q    <= 8'h00;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign pixel_out   = po_q;
    assign pixel_valid = pv_q;
    assign result      = result_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_pixel_streamer.sv
module tb_pixel_streamer;

    localparam int N  = 784;
    localparam int TO = 16;
    localparam int L0 = N * 1;   // stream span, PIX_GAP = 0
    localparam int L2 = N * 3;   // stream span, PIX_GAP = 2

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = 10'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic [1:0] dv_v = 2'b00;
    logic [3:0] din_v [2];
    logic [1:0] busy_v;
    logic [1:0] pv_v;
    logic [7:0] po_v [2];
    logic [3:0] res_v [2];
    logic [1:0] done_v;
    logic [1:0] terr_v;

    int n_cmp = 0;
    int n_bad = 0;
    int t_cyc = 0;

    always #5 clk = ~clk;

    pixel_streamer #(.IMG_PIXELS(N), .PIX_GAP(0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_v[0]), .pixel_out(po_v[0]), .pixel_valid(pv_v[0]),
        .digit_in(din_v[0]), .digit_valid(dv_v[0]), .result(res_v[0]),
        .done(done_v[0]), .timeout_err(terr_v[0]));

    pixel_streamer #(.IMG_PIXELS(N), .PIX_GAP(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_v[1]), .pixel_out(po_v[1]), .pixel_valid(pv_v[1]),
        .digit_in(din_v[1]), .digit_valid(dv_v[1]), .result(res_v[1]),
        .done(done_v[1]), .timeout_err(terr_v[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t_cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-based view: m_cyc is the number of cycles since the start was
    // accepted; slot k of the stream occupies cycles k*(gap+1) .. k*(gap+1)+gap.
    logic [7:0] mmem [2][N];
    bit         m_busy [2];
    int         m_cyc  [2];
    bit         e_pv   [2];
    logic [7:0] e_po   [2];
    logic [3:0] e_res  [2];
    bit         e_done [2];
    bit         e_terr [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int g;
            int l;
            int w;
            bit b0;
            g = (i == 0) ? 0 : 2;
            l = N * (g + 1);
            if (rst) begin
                m_busy[i] = 1'b0; m_cyc[i] = 0; e_pv[i] = 1'b0; e_po[i] = 8'h00;
                e_res[i] = 4'h0; e_done[i] = 1'b0; e_terr[i] = 1'b0;
            end else begin
                b0 = m_busy[i];
                e_done[i] = 1'b0;
                e_terr[i] = 1'b0;
                if (!b0) begin
                    if (start) begin
                        m_busy[i] = 1'b1;
                        m_cyc[i]  = 0;
                    end
                end else begin
                    if (m_cyc[i] >= l) begin
                        w = m_cyc[i] - l;
                        if (dv_v[i]) begin
                            e_res[i] = din_v[i]; e_done[i] = 1'b1; m_busy[i] = 1'b0;
                        end else if (w == TO - 1) begin
                            e_terr[i] = 1'b1; m_busy[i] = 1'b0;
                        end
                    end
                    if (m_busy[i]) m_cyc[i] = m_cyc[i] + 1;
                end
                if (m_busy[i] && m_cyc[i] < l && (m_cyc[i] % (g + 1)) == 0) begin
                    e_pv[i] = 1'b1;
                    e_po[i] = mmem[i][m_cyc[i] / (g + 1)];
                end else begin
                    e_pv[i] = 1'b0;
                    e_po[i] = 8'h00;
                end
                if (wr_en && !b0 && int'(wr_addr) < N) mmem[i][wr_addr] = wr_data;
            end
        end
    end

    // ---------------- per-cycle compare + stream statistics ----------------
    int v_cnt [2], run [2], max_run [2], last_px [2], first_px [2];
    int first_t [2], last_t [2], gap_bad [2], done_cnt [2], terr_cnt [2];

    task automatic reset_stats();
        for (int i = 0; i < 2; i++) begin
            v_cnt[i] = 0; run[i] = 0; max_run[i] = 0; last_px[i] = -1; first_px[i] = -1;
            first_t[i] = 0; last_t[i] = 0; gap_bad[i] = 0; done_cnt[i] = 0; terr_cnt[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        t_cyc++;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] act;
            logic [15:0] exp;
            act = {busy_v[i], pv_v[i], po_v[i], res_v[i], done_v[i], terr_v[i]};
            exp = {m_busy[i], e_pv[i], e_po[i], e_res[i], e_done[i], e_terr[i]};
            chk($sformatf("outs_dut%0d{busy,pv,px,res,done,terr}", i), int'(act), int'(exp));
            if (pv_v[i]) begin
                if (v_cnt[i] == 0) begin
                    first_px[i] = int'(po_v[i]);
                    first_t[i]  = t_cyc;
                end else if (t_cyc - last_t[i] != ((i == 0) ? 1 : 3)) begin
                    gap_bad[i]++;
                end
                v_cnt[i]++;
                last_t[i]  = t_cyc;
                last_px[i] = int'(po_v[i]);
                run[i]++;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end else begin
                run[i] = 0;
            end
            done_cnt[i] += int'(done_v[i]);
            terr_cnt[i] += int'(terr_v[i]);
        end
    end

    // ---------------- stimulus ----------------
    // One frame: start (unless already raised by the previous frame), then a
    // fixed cycle budget. Fixed side events: dropped write at s=50, ignored
    // start at s=60, ignored digit at s=70 (both DUTs still streaming).
    task automatic run_frame(input bit chained, input int dv0_at, input logic [3:0] d0,
                             input int dv2_at, input logic [3:0] d2,
                             input int rst_at, input bit chain_out);
        reset_stats();
        if (!chained) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 1; s <= L2 + TO + 4; s++) begin
            @(negedge clk);
            wr_en    = (s == 50);
            wr_addr  = 10'd0;
            wr_data  = 8'hFF;
            start    = (s == 60);
            dv_v[0]  = (s == dv0_at) || (s == 70);
            din_v[0] = (s == 70) ? 4'd9 : d0;
            dv_v[1]  = (s == dv2_at) || (s == 70);
            din_v[1] = (s == 70) ? 4'd9 : d2;
            if (s == rst_at) begin
                chk("pre_rst_pv_dut0", int'(pv_v[0]), 1);
                chk("pre_rst_px_dut0", int'(po_v[0]), rst_at % 256);
                rst = 1'b1;
                #1;
                chk("rst_immediate_pv", int'(pv_v), 0);
                chk("rst_immediate_busy", int'(busy_v), 0);
                @(negedge clk);
                rst = 1'b0;
                dv_v = 2'b00;
                return;
            end
            if (chain_out && s == dv2_at + 1) begin
                start = 1'b1;
                return;
            end
        end
        dv_v  = 2'b00;
        wr_en = 1'b0;
        chk("frame_finished_in_budget", int'(busy_v), 0);
    endtask

    task automatic random_writes(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            wr_en   = 1'b1;
            wr_addr = 10'($urandom_range(1, 1023));
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        din_v[0] = 4'd0;
        din_v[1] = 4'd0;
        reset_stats();
        repeat (3) @(negedge clk);
        chk("reset_outputs_dut0", int'({busy_v[0], pv_v[0], po_v[0], res_v[0], done_v[0], terr_v[0]}), 0);
        chk("reset_outputs_dut2", int'({busy_v[1], pv_v[1], po_v[1], res_v[1], done_v[1], terr_v[1]}), 0);
        rst = 1'b0;
        @(negedge clk);

        // buffer[i] = i[7:0], plus an out-of-range write that must be dropped
        for (int a = 0; a < N; a++) begin
            wr_en = 1'b1; wr_addr = 10'(a); wr_data = 8'(a);
            @(negedge clk);
        end
        wr_addr = 10'd900; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);

        // Frame A: dut0 answers 7 five cycles into WAIT, dut2 times out
        run_frame(1'b0, L0 + 5, 4'd7, -1, 4'd0, -1, 1'b0);
        chk("A_valid_count_dut0", v_cnt[0], 784);
        chk("A_consecutive_run_dut0", max_run[0], 784);
        chk("A_first_px_dut0", first_px[0], 0);
        chk("A_last_px_dut0", last_px[0], 15);
        chk("A_result_dut0", int'(res_v[0]), 7);
        chk("A_done_pulses_dut0", done_cnt[0], 1);
        chk("A_terr_pulses_dut0", terr_cnt[0], 0);
        chk("A_valid_count_dut2", v_cnt[1], 784);
        chk("A_span_first_to_last_dut2", last_t[1] - first_t[1], 2349);
        chk("A_gap_errors_dut2", gap_bad[1], 0);
        chk("A_terr_pulses_dut2", terr_cnt[1], 1);
        chk("A_done_pulses_dut2", done_cnt[1], 0);
        chk("A_result_held_dut2", int'(res_v[1]), 0);

        // Frame B: dut0 times out, dut2 answers on the expiry cycle; start
        // is raised in the cycle of dut2's done pulse.
        random_writes(60);
        run_frame(1'b0, -1, 4'd0, L2 + TO - 1, 4'd3, -1, 1'b1);
        chk("B_first_px_unchanged_dut0", first_px[0], 0);
        chk("B_terr_pulses_dut0", terr_cnt[0], 1);
        chk("B_result_held_dut0", int'(res_v[0]), 7);
        chk("B_done_pulses_dut2", done_cnt[1], 1);
        chk("B_terr_pulses_dut2", terr_cnt[1], 0);
        chk("B_result_dut2", int'(res_v[1]), 3);

        // Frame C: accepted from the chained start, aborted by reset at pixel 100
        run_frame(1'b1, -1, 4'd0, -1, 4'd0, 100, 1'b0);
        chk("C_first_px_dut0", first_px[0], 0);
        repeat (TO + 4) @(negedge clk);
        chk("C_no_done_after_rst", done_cnt[0] + done_cnt[1], 0);
        chk("C_no_terr_after_rst", terr_cnt[0] + terr_cnt[1], 0);

        // Frame D: first frame after reset must start at buffer[0]
        run_frame(1'b0, L0 + $urandom_range(0, 20), 4'($urandom),
                  L2 + $urandom_range(0, 20), 4'($urandom), -1, 1'b0);
        chk("D_first_px_dut0", first_px[0], 0);
        chk("D_first_px_dut2", first_px[1], 0);
        chk("D_valid_count_dut2", v_cnt[1], 784);

        // Randomised frames
        for (int f = 0; f < 3; f++) begin
            random_writes(40);
            run_frame(1'b0, $urandom_range(700, L0 + 20), 4'($urandom),
                      $urandom_range(2300, L2 + 20), 4'($urandom), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
